hub75_bcm_scan_ctrl: RTL and testbench

Scan sequencer for the 64x64 HUB75 panel path. Replaces the free-running external row/column/delay/index counter set plus its control FSM with one self-contained controller. Walks rows, columns and binary-code-modulation (BCM) bit planes, and drives the pixel-clock enable, latch and output-enable. Also owns the double-buffer swap handshake with the frame-buffer writer. Sits between the divided pixel clock domain and the frame buffer / `mux_led` bit-plane selector.

---
 rtl/hub75_bcm_scan_ctrl_pkg.sv | 36 +++
 rtl/bcm_ontime_timer.sv | 40 ++++
 rtl/hub75_bcm_scan_ctrl.sv | 151 +++++++++++++++
 tb/tb_hub75_bcm_scan_ctrl.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/hub75_bcm_scan_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// hub75_pkg
// Shared types and widths for the HUB75 scan controller.
//   scan_state_t : scan FSM states
//   COL_W/ROW_W/PLANE_W : counter widths for the 64x64 (1/32 scan) panel path
//   DELAY_W      : width of the plane-0 on-time input
//   ONTIME_W     : width of the on-time down-counter (2047 << 3 fits in 14 bits)
//   ontime_cycles() : on-time for a plane, with a base of 0 promoted to 1
// ---------------------------------------------------------------------------
package hub75_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_LATCH,
        ST_DISPLAY,
        ST_BLANK
    } scan_state_t;

    localparam int COL_W    = 6;
    localparam int ROW_W    = 5;
    localparam int PLANE_W  = 2;
    localparam int DELAY_W  = 11;
    localparam int ONTIME_W = 14;

    function automatic logic [ONTIME_W-1:0] ontime_cycles(
        input logic [DELAY_W-1:0] base,
        input logic [PLANE_W-1:0] shamt
    );
        logic [ONTIME_W-1:0] base_ext;
        // A zero base would give a zero-length DISPLAY; clamp it to one cycle.
        base_ext = (base == '0) ? ONTIME_W'(1) : ONTIME_W'(base);
        return base_ext << shamt;
    endfunction

endpackage

// File: rtl/bcm_ontime_timer.sv
// ---------------------------------------------------------------------------
// bcm_ontime_timer
// Loadable down-counter that times the output-enable window of one BCM plane.
//   clk      in  : pixel-domain clock
//   rst      in  : asynchronous active-high reset
//   i_load   in  : load max(i_base,1) << i_shift (asserted in LATCH)
//   i_run    in  : count down (asserted in DISPLAY)
//   i_shift  in  : plane index, i.e. the binary weight of the plane
//   i_base   in  : plane-0 on-time in cycles
//   o_done   out : last DISPLAY cycle (count has reached 1 while running)
// ---------------------------------------------------------------------------
module bcm_ontime_timer
    import hub75_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               i_load,
    input  logic               i_run,
    input  logic [PLANE_W-1:0] i_shift,
    input  logic [DELAY_W-1:0] i_base,
    output logic               o_done
);

    logic [ONTIME_W-1:0] r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= ontime_cycles(i_base, i_shift);
        end else if (i_run && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    // The first DISPLAY cycle sees the loaded value N, so reaching 1 marks
    // exactly N cycles with the output enabled.
    assign o_done = i_run && (r_count == ONTIME_W'(1));

endmodule

// File: rtl/hub75_bcm_scan_ctrl.sv
// ---------------------------------------------------------------------------
// hub75_bcm_scan_ctrl
// Row / column / BCM-plane scan sequencer for a HUB75 panel, including the
// double-buffer swap handshake with the frame-buffer writer.
//   clk        in  : pixel-domain (divided) clock
//   rst        in  : asynchronous active-high reset
//   en         in  : run enable, looked at only in IDLE and at frame end
//   base_delay in  : plane-0 on-time in cycles (0 behaves as 1)
//   swap_req   in  : level request to flip display buffers
//   swap_ack   out : one-cycle pulse when a swap is taken
//   buf_sel    out : buffer currently displayed
//   pix_addr   out : {row, col} frame-buffer read address
//   plane      out : current BCM bit plane
//   row        out : panel row address
//   px_clk_en  out : pixel shift clock enable
//   latch      out : active-high latch strobe
//   noe        out : active-high output disable
//   frame_done out : one-cycle pulse in the last cycle of each frame
// ---------------------------------------------------------------------------
module hub75_bcm_scan_ctrl
    import hub75_pkg::*;
#(
    parameter int COLS   = 64,
    parameter int ROWS   = 32,
    parameter int PLANES = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic [DELAY_W-1:0]       base_delay,
    input  logic                     swap_req,
    output logic                     swap_ack,
    output logic                     buf_sel,
    output logic [ROW_W+COL_W-1:0]   pix_addr,
    output logic [PLANE_W-1:0]       plane,
    output logic [ROW_W-1:0]         row,
    output logic                     px_clk_en,
    output logic                     latch,
    output logic                     noe,
    output logic                     frame_done
);

    scan_state_t        r_state;
    scan_state_t        w_state_next;

    logic [COL_W-1:0]   r_col;
    logic [ROW_W-1:0]   r_row;
    logic [PLANE_W-1:0] r_plane;

    logic               r_px_clk_en;
    logic               r_latch;
    logic               r_noe;
    logic               r_frame_done;
    logic               r_swap_ack;
    logic               r_buf_sel;

    logic               w_last_col;
    logic               w_last_plane;
    logic               w_last_row;
    logic               w_frame_end;
    logic               w_timer_done;
    logic               w_enter_frame_end;

    assign w_last_col   = (r_col   == COL_W'(COLS - 1));
    assign w_last_plane = (r_plane == PLANE_W'(PLANES - 1));
    assign w_last_row   = (r_row   == ROW_W'(ROWS - 1));
    assign w_frame_end  = w_last_plane && w_last_row;

    // row/plane hold through BLANK, so the frame-end BLANK is entered from
    // the last DISPLAY cycle of the last plane of the last row.
    assign w_enter_frame_end = (r_state == ST_DISPLAY) && w_timer_done && w_frame_end;

    bcm_ontime_timer u_ontime (
        .clk     (clk),
        .rst     (rst),
        .i_load  (r_state == ST_LATCH),
        .i_run   (r_state == ST_DISPLAY),
        .i_shift (r_plane),
        .i_base  (base_delay),
        .o_done  (w_timer_done)
    );

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:    if (en) w_state_next = ST_SHIFT;
            ST_SHIFT:   if (w_last_col) w_state_next = ST_LATCH;
            ST_LATCH:   w_state_next = ST_DISPLAY;
            ST_DISPLAY: if (w_timer_done) w_state_next = ST_BLANK;
            ST_BLANK: begin
                // en only matters at frame end: a running frame is never cut short.
                if (w_frame_end && !en) w_state_next = ST_IDLE;
                else                    w_state_next = ST_SHIFT;
            end
            default:    w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_col        <= '0;
            r_row        <= '0;
            r_plane      <= '0;
            r_px_clk_en  <= 1'b0;
            r_latch      <= 1'b0;
            r_noe        <= 1'b1;
            r_frame_done <= 1'b0;
            r_swap_ack   <= 1'b0;
            r_buf_sel    <= 1'b0;
        end else begin
            r_state <= w_state_next;

            // Strobes are decoded from the next state so they line up with
            // the state they belong to while still coming straight from flops.
            r_px_clk_en  <= (w_state_next == ST_SHIFT);
            r_latch      <= (w_state_next == ST_LATCH);
            r_noe        <= (w_state_next != ST_DISPLAY);
            r_frame_done <= w_enter_frame_end;
            r_swap_ack   <= w_enter_frame_end && swap_req;
            if (w_enter_frame_end && swap_req) begin
                r_buf_sel <= ~r_buf_sel;
            end

            if (r_state == ST_SHIFT) begin
                r_col <= w_last_col ? '0 : r_col + 1'b1;
            end

            // Advancing on BLANK exit keeps row stable while noe is low.
            if (r_state == ST_BLANK) begin
                if (w_last_plane) begin
                    r_plane <= '0;
                    r_row   <= w_last_row ? '0 : r_row + 1'b1;
                end else begin
                    r_plane <= r_plane + 1'b1;
                end
            end
        end
    end

    assign pix_addr   = {r_row, r_col};
    assign plane      = r_plane;
    assign row        = r_row;
    assign px_clk_en  = r_px_clk_en;
    assign latch      = r_latch;
    assign noe        = r_noe;
    assign frame_done = r_frame_done;
    assign swap_ack   = r_swap_ack;
    assign buf_sel    = r_buf_sel;

endmodule

// File: tb/tb_hub75_bcm_scan_ctrl.sv
// ---------------------------------------------------------------------------
// tb_hub75_bcm_scan_ctrl
// Stimulus pushes expected pixel addresses, shift-burst lengths, noe low-pulse
// widths/rows and per-frame results into queues; a negedge monitor pops and
// compares them as the DUT produces each event.
// ---------------------------------------------------------------------------
module tb_hub75_bcm_scan_ctrl;
    import hub75_pkg::*;

    logic                   clk;
    logic                   rst;
    logic                   en;
    logic [DELAY_W-1:0]     base_delay;
    logic                   swap_req;
    logic                   swap_ack;
    logic                   buf_sel;
    logic [ROW_W+COL_W-1:0] pix_addr;
    logic [PLANE_W-1:0]     plane;
    logic [ROW_W-1:0]       row;
    logic                   px_clk_en;
    logic                   latch;
    logic                   noe;
    logic                   frame_done;

    hub75_bcm_scan_ctrl #(.COLS(64), .ROWS(32), .PLANES(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .base_delay (base_delay),
        .swap_req   (swap_req),
        .swap_ack   (swap_ack),
        .buf_sel    (buf_sel),
        .pix_addr   (pix_addr),
        .plane      (plane),
        .row        (row),
        .px_clk_en  (px_clk_en),
        .latch      (latch),
        .noe        (noe),
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct { int width; int row; } pulse_t;
    typedef struct { int period; int ack; int bsel; } frame_t;

    int     q_addr[$];
    int     q_burst[$];
    pulse_t q_width[$];
    frame_t q_frame[$];

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // ---------------- monitor ----------------
    int px_run    = 0;
    int pw        = 0;
    int row_start = 0;
    int frm_cnt   = 0;
    bit in_pulse  = 0;
    bit row_moved = 0;

    always @(negedge clk) begin
        if (rst) begin
            px_run   = 0;
            pw       = 0;
            in_pulse = 0;
            frm_cnt  = 0;
        end else begin
            if (px_clk_en) begin
                px_run++;
                if (q_addr.size() != 0) begin
                    int ea;
                    ea = q_addr.pop_front();
                    check("pix_addr", int'(pix_addr), ea);
                end
            end
            if (latch && q_burst.size() != 0) begin
                int eb;
                eb = q_burst.pop_front();
                check("shift_burst_len", px_run, eb);
            end
            if (!px_clk_en) px_run = 0;

            if (!noe) begin
                if (!in_pulse) begin
                    in_pulse  = 1;
                    pw        = 0;
                    row_start = int'(row);
                    row_moved = 0;
                end
                if (int'(row) != row_start) row_moved = 1;
                pw++;
            end else if (in_pulse) begin
                in_pulse = 0;
                if (q_width.size() != 0) begin
                    pulse_t ep;
                    ep = q_width.pop_front();
                    $display("pulse row %0d width %0d (expect row %0d width %0d)",
                             row_start, pw, ep.row, ep.width);
                    check("noe_width", pw, ep.width);
                    check("noe_row", row_start, ep.row);
                    check("row_stable_noe_low", int'(row_moved), 0);
                end
            end

            frm_cnt++;
            if (swap_ack && !frame_done) check("swap_ack_outside_frame_end", 1, 0);
            if (frame_done) begin
                if (q_frame.size() != 0) begin
                    frame_t ef;
                    ef = q_frame.pop_front();
                    $display("frame_done period %0d swap_ack %0d buf_sel %0d",
                             frm_cnt, swap_ack, buf_sel);
                    if (ef.period != 0) check("frame_period", frm_cnt, ef.period);
                    check("swap_ack", int'(swap_ack), ef.ack);
                    check("buf_sel", int'(buf_sel), ef.bsel);
                end
                frm_cnt = 0;
            end
        end
    end

    // ---------------- bounded waits ----------------
    task automatic wait_fd(input int budget);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!frame_done && n < budget);
        if (!frame_done) check("timeout_frame_done", 0, 1);
    endtask

    task automatic wait_row(input int r, input int budget);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (int'(row) != r && n < budget);
        if (int'(row) != r) check("timeout_row", int'(row), r);
    endtask

    task automatic wait_disp(input int r, input int p, input int budget);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(int'(row) == r && int'(plane) == p && !noe) && n < budget);
        if (noe) check("timeout_display", 1, 0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int bad;
        rst        = 1'b1;
        en         = 1'b0;
        base_delay = 11'd10;
        swap_req   = 1'b0;
        repeat (3) @(negedge clk);

        check("rst_noe", noe, 1);
        check("rst_latch", latch, 0);
        check("rst_px_clk_en", px_clk_en, 0);
        check("rst_pix_addr", pix_addr, 0);
        check("rst_plane", plane, 0);
        check("rst_buf_sel", buf_sel, 0);
        check("rst_swap_ack", swap_ack, 0);
        check("rst_frame_done", frame_done, 0);
        rst = 1'b0;

        bad = 0;
        repeat (5) begin
            @(negedge clk);
            if (!noe || latch || px_clk_en) bad++;
        end
        check("idle_outputs", bad, 0);

        // Frame 1 (base_delay 10): 64-address burst, every noe pulse of the
        // frame, and row 0 plane 0 of the next frame to see the row wrap.
        for (int i = 0; i < 64; i++) q_addr.push_back(i);
        q_burst.push_back(64);
        for (int r = 0; r < 32; r++)
            for (int p = 0; p < 4; p++)
                q_width.push_back('{10 << p, r});
        q_width.push_back('{10, 0});
        q_frame.push_back('{0, 1, 1});
        q_frame.push_back('{13248, 1, 0});
        q_frame.push_back('{13248, 1, 1});

        en = 1'b1;
        @(negedge clk);
        check("first_px_clk_en", px_clk_en, 1);

        wait_row(10, 20000);
        swap_req = 1'b1;
        repeat (100) @(negedge clk);
        check("midframe_buf_sel", buf_sel, 0);
        check("midframe_swap_ack", swap_ack, 0);

        wait_fd(20000);          // frame 1: swap taken
        wait_fd(20000);          // frame 2: request held, swap back
        swap_req = 1'b0;
        wait_row(3, 20000);
        swap_req = 1'b1;
        wait_fd(20000);          // frame 3: swap again
        swap_req   = 1'b0;
        base_delay = 11'd0;
        @(posedge clk);
        for (int p = 0; p < 4; p++) q_width.push_back('{1 << p, 0});
        q_frame.push_back('{8928, 0, 1});

        wait_row(5, 20000);
        en = 1'b0;
        wait_fd(20000);          // frame 4 completes despite en low
        bad = 0;
        repeat (100) begin
            @(negedge clk);
            if (!noe || latch || px_clk_en) bad++;
        end
        check("idle_after_en_drop", bad, 0);

        // Restart and hit the DUT with reset in the middle of DISPLAY.
        base_delay = 11'd10;
        en = 1'b1;
        wait_disp(1, 2, 5000);
        #1 rst = 1'b1;
        #1;
        check("async_rst_noe", noe, 1);
        @(negedge clk);
        check("after_rst_row", row, 0);
        check("after_rst_plane", plane, 0);
        check("after_rst_pix_addr", pix_addr, 0);
        check("after_rst_buf_sel", buf_sel, 0);
        rst = 1'b0;
        @(negedge clk);
        check("restart_px_clk_en", px_clk_en, 1);
        check("restart_pix_addr", pix_addr, 0);

        repeat (4) @(negedge clk);
        check("queues_drained",
              q_addr.size() + q_burst.size() + q_width.size() + q_frame.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
